// File: rtl/led_pwm_ctrl_if.sv
// rtl/led_pwm_ctrl_if.sv - register bus between a host and the LED PWM controller
interface led_pwm_ctrl_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        response;

  modport master (
    output read, write, address, write_data,
    input  read_data, response
  );

  modport slave (
    input  read, write, address, write_data,
    output read_data, response
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED driver with per-channel PWM duty and blink gating
module led_pwm_ctrl #(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  led_pwm_ctrl_if.slave       bus,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
  localparam logic [NUM_LEDS-1:0] PIN_INV   = {NUM_LEDS{(ACTIVE_LOW != 0)}};

  logic [NUM_LEDS-1:0]                enable;
  logic [NUM_LEDS-1:0]                blink_en;
  logic [BLINK_BITS-1:0]              blink_period;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [BLINK_BITS-1:0]              blink_cnt;
  logic                               blink_phase;
  logic [NUM_LEDS-1:0]                led_on;
  logic [31:0]                        rd_value;

  // Only address[7:2] selects a register; the rest of the bus word is don't-care.
  logic [5:0] word;
  logic [3:0] duty_idx;
  logic       duty_sel;
  logic       wr_period;
  logic       unused_bus_bits;

  assign word            = bus.address[7:2];
  assign duty_idx        = word[3:0];
  assign duty_sel        = (word[5:4] == 2'b01) && ({1'b0, duty_idx} < 5'(NUM_LEDS));
  assign wr_period       = bus.write && (word == 6'd2);
  assign unused_bus_bits = ^{bus.address, bus.write_data};

  // Configuration registers; reset wins over any simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable       <= '0;
      blink_en     <= '0;
      blink_period <= '0;
      duty         <= {NUM_LEDS{DUTY_FULL}};
    end else if (bus.write) begin
      if (word == 6'd0) enable   <= bus.write_data[NUM_LEDS-1:0];
      if (word == 6'd1) blink_en <= bus.write_data[NUM_LEDS-1:0];
      if (wr_period)    blink_period <= bus.write_data[BLINK_BITS-1:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (duty_sel && (duty_idx == 4'(i))) duty[i] <= bus.write_data[PWM_BITS-1:0];
      end
    end
  end

  // Free-running PWM ramp shared by all channels.
  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Blink timebase: phase flips every blink_period cycles; a period write restarts it in the on phase.
  always_ff @(posedge clk) begin
    if (reset || wr_period || (blink_period == '0)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt >= blink_period - BLINK_BITS'(1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_BITS'(1);
    end
  end

  // Per-channel on decision: enable, PWM compare (full duty pinned on), blink gating.
  always_comb begin
    led_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_on[i] = enable[i]
                & ((duty[i] == DUTY_FULL) | (pwm_cnt < duty[i]))
                & (~blink_en[i] | blink_phase);
    end
  end

  // Pin drive is registered and optionally inverted for sink-driven LEDs.
  always_ff @(posedge clk) begin
    if (reset) leds <= PIN_INV;
    else       leds <= led_on ^ PIN_INV;
  end

  // Read mux: zero-extended register value, zero for anything unmapped.
  always_comb begin
    rd_value = '0;
    case (word)
      6'd0:    rd_value[NUM_LEDS-1:0]   = enable;
      6'd1:    rd_value[NUM_LEDS-1:0]   = blink_en;
      6'd2:    rd_value[BLINK_BITS-1:0] = blink_period;
      6'd3:    rd_value[0]              = blink_phase;
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (duty_sel && (duty_idx == 4'(i))) rd_value[PWM_BITS-1:0] = duty[i];
        end
      end
    endcase
  end

  // One-cycle acknowledge; read data is suppressed when a write shares the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.response  <= 1'b0;
      bus.read_data <= '0;
    end else begin
      bus.response  <= bus.read | bus.write;
      bus.read_data <= (bus.read && !bus.write) ? rd_value : 32'd0;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - randomized self-checking bench for led_pwm_ctrl
module tb_led_pwm_ctrl;
  localparam int NL = 8;
  localparam int PB = 8;
  localparam int BB = 24;
  localparam int AL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] leds;
  led_pwm_ctrl_if bus ();

  led_pwm_ctrl #(.NUM_LEDS(NL), .PWM_BITS(PB), .BLINK_BITS(BB), .ACTIVE_LOW(AL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int per_cyc = 0;

  logic [NL-1:0] m_en;
  logic [NL-1:0] m_ben;
  logic [BB-1:0] m_per;
  logic [PB-1:0] m_duty [NL];

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
  endtask

  function automatic void model_reset();
    m_en = '0;
    m_ben = '0;
    m_per = '0;
    for (int i = 0; i < NL; i++) m_duty[i] = '1;
    rst_cyc = cyc;
    per_cyc = cyc;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    int w;
    w = int'(a[7:2]);
    if (w == 0) m_en = d[NL-1:0];
    else if (w == 1) m_ben = d[NL-1:0];
    else if (w == 2) begin
      m_per = d[BB-1:0];
      per_cyc = cyc;
    end else if (w >= 16 && (w - 16) < NL) m_duty[w-16] = d[PB-1:0];
  endfunction

  // Blink phase from elapsed cycles since the last restart of the timebase.
  function automatic logic phase_now();
    int j;
    if (m_per == '0) return 1'b1;
    j = cyc - 1 - per_cyc;
    return ((j / int'(m_per)) % 2) == 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    w = int'(a[7:2]);
    if (w == 0) return 32'(m_en);
    if (w == 1) return 32'(m_ben);
    if (w == 2) return 32'(m_per);
    if (w == 3) return 32'(phase_now());
    if (w >= 16 && (w - 16) < NL) return 32'(m_duty[w-16]);
    return 32'd0;
  endfunction

  function automatic logic [NL-1:0] model_leds();
    int p;
    logic on;
    logic [NL-1:0] r;
    p = (cyc - 1 - rst_cyc) % (1 << PB);
    for (int i = 0; i < NL; i++) begin
      on = m_en[i] && ((m_duty[i] == {PB{1'b1}}) || (p < int'(m_duty[i])))
           && (!m_ben[i] || phase_now());
      r[i] = on ^ (AL != 0);
    end
    return r;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic r);
    bus.write = 1'b1;
    bus.address = a;
    bus.write_data = d;
    tick();
    r = bus.response;
    model_write(a, d);
    bus_idle();
  endtask

  task automatic do_read(input logic [31:0] a, output logic r, output logic [31:0] rd);
    bus.read = 1'b1;
    bus.address = a;
    tick();
    r = bus.response;
    rd = bus.read_data;
    bus_idle();
  endtask

  task automatic apply_reset(input logic with_write);
    reset = 1'b1;
    if (with_write) begin
      bus.write = 1'b1;
      bus.read = 1'b0;
      bus.address = 32'h0;
      bus.write_data = 32'hFF;
    end
    tick();
    reset = 1'b0;
    bus_idle();
    model_reset();
  endtask

  task automatic test_reset();
    logic r;
    logic [31:0] rd;
    logic [31:0] addrs [6];
    logic [31:0] exps [6];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h5C};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h1, 32'hFF, 32'hFF};
    apply_reset(1'b0);
    checks++; if (bus.response !== 1'b0) begin errors++; $display("FAIL reset_response got %b want 0", bus.response); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", bus.read_data); end
    checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL reset_leds got %h want ff", leds); end
    for (int i = 0; i < 6; i++) begin
      do_read(addrs[i], r, rd);
      checks++; if (r !== 1'b1 || rd !== exps[i]) begin
        errors++; $display("FAIL reset_reg addr %h got resp %b data %h want 1 %h", addrs[i], r, rd, exps[i]);
      end
    end
  endtask

  task automatic test_enable();
    logic r;
    do_write(32'h00, 32'hA5, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL enable_ack got %b want 1", r); end
    tick();
    checks++; if (bus.response !== 1'b0) begin errors++; $display("FAIL enable_ack_len got %b want 0", bus.response); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL enable_leds cyc %0d got %h want 5a", i, leds); end
      tick();
    end
  endtask

  task automatic pwm_window(input logic [31:0] duty0, input int want_low, input string nm);
    logic r;
    int low;
    do_write(32'h40, duty0, r);
    low = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (leds[0] === 1'b0) low++;
      checks++; if (leds !== model_leds()) begin
        errors++; $display("FAIL %s_leds step %0d got %h want %h", nm, i, leds, model_leds());
      end
    end
    checks++; if (low !== want_low) begin errors++; $display("FAIL %s_low_count got %0d want %0d", nm, low, want_low); end
  endtask

  task automatic test_pwm();
    logic r;
    do_write(32'h00, 32'h01, r);
    pwm_window(32'd64, 64, "pwm64");
    pwm_window(32'd0, 0, "pwm0");
    pwm_window(32'd255, 256, "pwm255");
  endtask

  task automatic test_blink();
    logic r;
    logic [31:0] rd;
    logic prev;
    int toggles;
    do_write(32'h00, 32'h03, r);
    do_write(32'h04, 32'h02, r);
    do_write(32'h08, 32'd10, r);
    toggles = 0;
    tick();
    checks++; if (leds[1] !== 1'b0) begin errors++; $display("FAIL blink_start got %b want 0", leds[1]); end
    prev = leds[1];
    for (int i = 0; i < 60; i++) begin
      checks++; if (leds !== model_leds()) begin
        errors++; $display("FAIL blink_leds step %0d got %h want %h", i, leds, model_leds());
      end
      checks++; if (leds[0] !== 1'b0) begin errors++; $display("FAIL blink_steady step %0d got %b want 0", i, leds[0]); end
      if (leds[1] !== prev) toggles++;
      prev = leds[1];
      if (i < 59) tick();
    end
    checks++; if (toggles !== 5) begin errors++; $display("FAIL blink_toggles got %0d want 5", toggles); end
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 6)) tick();
      do_read(32'h0C, r, rd);
      checks++; if (r !== 1'b1 || rd !== model_read(32'h0C)) begin
        errors++; $display("FAIL blink_status got %b %h want 1 %h", r, rd, model_read(32'h0C));
      end
    end
  endtask

  task automatic test_regs();
    logic r;
    logic [31:0] rd;
    logic [31:0] ign [3];
    ign = '{32'h0C, 32'h60, 32'h80};
    do_write(32'h4C, 32'h1234_5677, r);
    do_read(32'h4C, r, rd);
    checks++; if (r !== 1'b1 || rd !== 32'h77) begin errors++; $display("FAIL duty3_read got %b %h want 1 77", r, rd); end
    tick();
    checks++; if (bus.response !== 1'b0 || bus.read_data !== 32'h0) begin
      errors++; $display("FAIL read_data_idle got %b %h want 0 0", bus.response, bus.read_data);
    end
    do_read(32'h80, r, rd);
    checks++; if (r !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %b %h want 1 0", r, rd); end
    for (int i = 0; i < 3; i++) begin
      do_write(ign[i], 32'hFFFF_FFFF, r);
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL ignored_ack addr %h got %b want 1", ign[i], r); end
    end
    do_read(32'h60, r, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL duty8_read got %h want 0", rd); end
    do_read(32'h00, r, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL ignored_enable got %h want 3", rd); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    case ($urandom_range(0, 6))
      0: lo = 32'h00;
      1: lo = 32'h04;
      2: lo = 32'h08;
      3: lo = 32'h0C;
      4: lo = 32'h40 + 4 * $urandom_range(0, 15);
      5: lo = 32'h80 + 4 * $urandom_range(0, 31);
      default: lo = 32'h40 + 4 * $urandom_range(0, 7);
    endcase
    return ($urandom & 32'hFFFF_FF03) | lo;
  endfunction

  task automatic test_random();
    logic r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    for (int k = 0; k < 40; k++) begin
      a = rand_addr();
      d = (a[7:2] == 6'd2) ? (($urandom & 32'hFF00_0000) | $urandom_range(0, 12)) : $urandom;
      do_write(a, d, r);
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL rand_write_ack addr %h got %b want 1", a, r); end
      a = rand_addr();
      do_read(a, r, rd);
      checks++; if (r !== 1'b1 || rd !== model_read(a)) begin
        errors++; $display("FAIL rand_read addr %h got %b %h want 1 %h", a, r, rd, model_read(a));
      end
    end
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++; if (leds !== model_leds()) begin
        errors++; $display("FAIL rand_leds step %0d got %h want %h", i, leds, model_leds());
      end
    end
  endtask

  task automatic test_rw_both();
    logic r;
    logic [31:0] rd;
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.address = 32'h04;
    bus.write_data = 32'hFF;
    tick();
    checks++; if (bus.response !== 1'b1 || bus.read_data !== 32'h0) begin
      errors++; $display("FAIL rw_both got %b %h want 1 0", bus.response, bus.read_data);
    end
    model_write(32'h04, 32'hFF);
    bus_idle();
    tick();
    checks++; if (bus.response !== 1'b0) begin errors++; $display("FAIL rw_both_single got %b want 0", bus.response); end
    do_read(32'h04, r, rd);
    checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL rw_both_reg got %h want ff", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 4 * i;
      d = $urandom;
      bus.write = 1'b1;
      bus.address = a;
      bus.write_data = d;
      tick();
      checks++; if (bus.response !== 1'b1) begin errors++; $display("FAIL b2b_write %0d got %b want 1", i, bus.response); end
      model_write(a, d);
    end
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 4 * i;
      bus.read = 1'b1;
      bus.address = a;
      tick();
      checks++; if (bus.response !== 1'b1 || bus.read_data !== model_read(a)) begin
        errors++; $display("FAIL b2b_read %0d got %b %h want 1 %h", i, bus.response, bus.read_data, model_read(a));
      end
    end
    bus_idle();
    tick();
    checks++; if (bus.response !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", bus.response); end
  endtask

  task automatic test_reset_mid();
    logic r;
    logic [31:0] rd;
    logic [31:0] addrs [5];
    logic [31:0] exps [5];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h1, 32'hFF};
    do_write(32'h00, 32'hFF, r);
    do_write(32'h04, 32'hAA, r);
    do_write(32'h08, 32'd7, r);
    do_write(32'h40, 32'd64, r);
    repeat (23) tick();
    apply_reset(1'b1);
    checks++; if (bus.response !== 1'b0) begin errors++; $display("FAIL midreset_resp got %b want 0", bus.response); end
    checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL midreset_leds got %h want ff", leds); end
    tick();
    checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL midreset_leds_after got %h want ff", leds); end
    for (int i = 0; i < 5; i++) begin
      do_read(addrs[i], r, rd);
      checks++; if (rd !== exps[i]) begin errors++; $display("FAIL midreset_reg addr %h got %h want %h", addrs[i], rd, exps[i]); end
    end
    do_write(32'h00, 32'h03, r);
    do_write(32'h40, 32'd100, r);
    do_write(32'h04, 32'h02, r);
    do_write(32'h08, 32'd5, r);
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++; if (leds !== model_leds()) begin
        errors++; $display("FAIL midreset_restart step %0d got %h want %h", i, leds, model_leds());
      end
    end
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    test_reset();
    test_enable();
    test_pwm();
    test_blink();
    test_regs();
    test_rw_both();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
